prio_enc_rr_arb: RTL
====================

Name: prio_enc_rr_arb

Overview:
- Parametrised, registered successor of the 4-to-2 priority encoder.
- Encodes N request lines into a held grant (index plus one-hot) with a valid/ack handshake.
- Two modes, selectable at run time: fixed priority (highest index wins) and round-robin.
- Sits between request sources and a shared resource; the grant is held until the consumer acknowledges.

Parameters:
- N, 8, number of request lines; legal range 2..64.
- W, $clog2(N), index width; derived localparam, not overridable.
- TIMEOUT, 16, grant watchdog limit in cycles; used only with PRIO_ENC_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- req  in  N  request vector; bit i asserted means requester i wants the resource.
- mode  in  1  0 = fixed priority, 1 = round-robin; sampled only when an arbitration decision is made.
- ack  in  1  consumer has finished with the current grant; meaningful only while gnt_vld=1.
- gnt_vld  out  1  a grant is held.
- gnt_idx  out  W  index of the granted requester.
- gnt_oh  out  N  one-hot copy of gnt_idx; all zero when gnt_vld=0.
- timeout  out  1  one-cycle pulse on forced release; exists only with the macro.

Behaviour:
- Reset (rst_n=0 at a posedge): gnt_vld=0, gnt_idx=0, gnt_oh=0, timeout=0, rr pointer=0, state=IDLE. Reset mid-grant drops the grant on the next edge, with no ack required.
- States: IDLE and GRANT.
- IDLE:
  - If |req, arbitrate on this cycle's req; next cycle state=GRANT, gnt_vld=1, with the winner's idx/oh. Latency from req to gnt_vld is 1 cycle.
  - Otherwise stay in IDLE.
- Fixed mode: the highest set index wins. Example: req=0b1010 grants idx 3.
- Round-robin mode:
  - After granting k, the search order is k-1, k-2, ..., 0, N-1, ..., k (wrap-around).
  - The pointer holds the last granted index; pointer=0 after reset, so the first RR search order equals fixed order.
  - The pointer updates only on a completed grant (ack). In fixed mode it also tracks the last completed grant, so switching to RR continues fairly.
- GRANT:
  - Outputs are held stable while ack=0 and req[gnt_idx]=1.
  - ack=1: the grant completes and the pointer becomes gnt_idx. In the same cycle, re-arbitrate on current req using the updated pointer. If any req is set, the new grant appears next cycle (back-to-back, no idle bubble); otherwise go to IDLE with gnt_vld=0.
  - req[gnt_idx]=0 with ack=0: abort. Go to IDLE next cycle, gnt_vld=0, pointer unchanged.
  - ack=1 together with req[gnt_idx]=0: treated as completion (ack wins).
- A mode change while in GRANT has no effect until the next arbitration.
- ack while gnt_vld=0 is ignored.
- N that is not a power of two: indices ≥ N are never produced.

Optional Feature:
- Macro: PRIO_ENC_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each GRANT cycle without ack.
  - When the counter reaches TIMEOUT-1 without ack, the grant is force-released as if acked, with the pointer updated so the hog loses priority.
  - timeout pulses 1 for exactly that release cycle and re-arbitration proceeds as for ack.
  - timeout is 0 at reset.
- Undefined: no counter, no timeout port; a grant is held indefinitely.

Decomposition:
- Package prio_enc_pkg: state encoding (IDLE, GRANT), mode constants (MODE_FIXED=0, MODE_RR=1), and a function for the rotated-vector index wrap.
- Sub-module prio_pick: a combinational, parametrised N-bit highest-set-bit finder with any/idx outputs. Instantiate it once on the rotated request vector; fixed mode uses rotation 0.

Test Plan (N=4):
- Reset/idle: hold rst_n=0 for 2 cycles with req=0b1111 -> gnt_vld=0, gnt_oh=0; release, next cycle gnt_idx=3, gnt_oh=0b1000.
- Fixed priority: mode=0, req=0b0110, ack pulse each grant -> grants 2,2,2 (index 1 is starved); then req=0b0001 -> grant 0.
- Round-robin: mode=1, req=0b1111, ack every cycle -> gnt_idx sequence 3,2,1,0,3 with gnt_vld continuously 1.
- Abort: grant idx 2, then drop req[2] with ack=0 -> gnt_vld=0 next cycle; with req=0b0100 re-raised, idx 2 is granted again (pointer unchanged).
- Mid-grant reset and ack-without-grant: rst_n=0 during GRANT -> outputs zero next edge; ack=1 in IDLE with req=0 -> no change.
- With PRIO_ENC_TIMEOUT_EN and TIMEOUT=4: mode=1, req=0b1001 held, ack=0 -> idx 3 is held 4 cycles, timeout pulses for one cycle, next grant is idx 0.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared types, mode constants and index-wrap helper for the arbiter
package prio_enc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // (a + b) mod n for operands already below n; avoids a real divider.
  function automatic int rr_wrap(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational N-bit highest-set-bit finder
module prio_pick #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    any_o = |vec_i;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/prio_enc_rr_arb.sv
// rtl/prio_enc_rr_arb.sv - registered fixed/round-robin arbiter with held grant and ack handshake
// Optional grant watchdog with timeout port: define PRIO_ENC_TIMEOUT_EN.
module prio_enc_rr_arb
  import prio_enc_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int TIMEOUT = 16,
  localparam int W       = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic         gnt_vld,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_oh
`ifdef PRIO_ENC_TIMEOUT_EN
  ,
  output logic         timeout
`endif
);

  if (N < 2 || N > 64 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("prio_enc_rr_arb: parameter out of range");
  end

  state_e       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] rot_amt, pick_idx, win_idx;
  logic [N-1:0] rot_req;
  logic         pick_any, force_rel, done;

`ifdef PRIO_ENC_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign force_rel = (state_q == GRANT) && !ack && (cnt_q == 8'(TIMEOUT - 1));
`else
  assign force_rel = 1'b0;
`endif

  assign done = (state_q == GRANT) && (ack || force_rel);

  // Rotating by the last grant k puts k-1 at the MSB, so a highest-bit pick yields the RR order.
  always_comb begin
    rot_amt = '0;
    if (mode == MODE_RR) rot_amt = done ? idx_q : ptr_q;
  end

  always_comb begin
    rot_req = '0;
    for (int j = 0; j < N; j++) begin
      rot_req[j] = req[W'(rr_wrap(j, int'(rot_amt), N))];
    end
  end

  prio_pick #(.N(N)) u_pick (
    .vec_i (rot_req),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  assign win_idx = W'(rr_wrap(int'(pick_idx), int'(rot_amt), N));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          idx_d   = win_idx;
        end
      end
      GRANT: begin
        if (done) begin
          ptr_d = idx_q;
          if (pick_any) begin
            idx_d = win_idx;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else if (!req[idx_q]) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_vld = (state_q == GRANT);
    gnt_idx = idx_q;
    gnt_oh  = '0;
    if (state_q == GRANT) gnt_oh[idx_q] = 1'b1;
  end

`ifdef PRIO_ENC_TIMEOUT_EN
  // Counter restarts on every fresh grant, including back-to-back ones.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == GRANT && (state_q == IDLE || done)) cnt_d = '0;
    else if (state_q == GRANT) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout = force_rel;
`endif

endmodule
